// File: rtl/flow_pkg.sv
// Shared definitions for the flow_check sink: beat-0 field layout, per-flow stats record,
// FSM state encoding and the saturating error-counter increment.
package flow_pkg;

    localparam int unsigned MAC_W   = 48;
    localparam int unsigned ETYPE_W = 16;
    localparam int unsigned PROTO_W = 8;
    localparam int unsigned IP_W    = 32;
    localparam int unsigned PORT_W  = 16;
    localparam int unsigned SEQ_W   = 32;
    localparam int unsigned TS_W    = 32;

    // Beat-0 bit offsets, fields packed upward from bit 0
    localparam int unsigned DST_MAC_OFF  = 0;
    localparam int unsigned ETYPE_OFF    = DST_MAC_OFF + MAC_W;
    localparam int unsigned PROTO_OFF    = ETYPE_OFF + ETYPE_W;
    localparam int unsigned DST_IP_OFF   = PROTO_OFF + PROTO_W;
    localparam int unsigned SRC_PORT_OFF = DST_IP_OFF + IP_W;
    localparam int unsigned DST_PORT_OFF = SRC_PORT_OFF + PORT_W;
    localparam int unsigned SEQ_OFF      = DST_PORT_OFF + PORT_W;
    localparam int unsigned TS_OFF       = SEQ_OFF + SEQ_W;

    localparam int unsigned PKT_W  = 32;
    localparam int unsigned BYTE_W = 48;
    localparam int unsigned ERR_W  = 16;
    localparam int unsigned LAT_W  = 32;

    typedef struct packed {
        logic [PKT_W-1:0]  pkt_cnt;
        logic [BYTE_W-1:0] byte_cnt;
        logic [ERR_W-1:0]  hdr_err;
        logic [ERR_W-1:0]  seq_err;
        logic [LAT_W-1:0]  lat_max;
    } flow_stat_t;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/flow_stat_regs.sv
// Per-flow statistics register file: one commit port, global clear, registered read port.
// A clear coinciding with a commit zeroes everything, then applies that commit on top.
module flow_stat_regs
    import flow_pkg::*;
#(
    parameter int unsigned NUM_FLOWS = 16,
    localparam int unsigned FLOW_W   = $clog2(NUM_FLOWS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              commit_i,
    input  logic [FLOW_W-1:0] commit_flow_i,
    input  logic [BYTE_W-1:0] bytes_i,
    input  logic              hdr_err_i,
    input  logic              seq_err_i,
    input  logic [LAT_W-1:0]  lat_i,
    input  logic [FLOW_W-1:0] rd_sel_i,
    output flow_stat_t        rd_data_o
);

    flow_stat_t mem_q [NUM_FLOWS];
    flow_stat_t rd_q;
    flow_stat_t base;
    flow_stat_t upd;

    // Updated record for the committing flow, built on a zeroed base when clearing
    always_comb begin
        base = clear_i ? flow_stat_t'('0) : mem_q[commit_flow_i];
        upd  = base;
        upd.pkt_cnt  = base.pkt_cnt + PKT_W'(1);
        upd.byte_cnt = base.byte_cnt + bytes_i;
        if (hdr_err_i) begin
            upd.hdr_err = sat_inc(base.hdr_err);
        end
        if (seq_err_i) begin
            upd.seq_err = sat_inc(base.seq_err);
        end
        if (lat_i > base.lat_max) begin
            upd.lat_max = lat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
                mem_q[FLOW_W'(i)] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (clear_i) begin
                for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
                    mem_q[FLOW_W'(i)] <= '0;
                end
            end
            if (commit_i) begin
                mem_q[commit_flow_i] <= upd;
            end
            rd_q <= mem_q[rd_sel_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/flow_check.sv
// H2C packet sink: parses beat 0 of each packet, checks header/sequence, and accumulates
// per-flow packet, byte, error and max-latency statistics with a CSR readback port.
module flow_check
    import flow_pkg::*;
#(
    parameter int unsigned RX_LEN          = 512,
    parameter int unsigned NUM_FLOWS       = 16,
    parameter logic [31:0] GLOBAL_DST_IP   = 32'hC0A8640A,
    parameter logic [15:0] GLOBAL_DST_PORT = 16'h1234,
    parameter logic [7:0]  GLOBAL_PROTOCOL = 8'h06,
    parameter logic [47:0] GLOBAL_DST_MAC  = 48'h001112345678,
    localparam int unsigned FLOW_W         = $clog2(NUM_FLOWS)
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,
    input  logic [31:0]         timestamp,
    input  logic                s_axis_tvalid,
    input  logic [RX_LEN-1:0]   s_axis_tdata,
    input  logic [RX_LEN/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    input  logic [FLOW_W-1:0]   stat_sel,
    input  logic                stat_clear,
    output logic [31:0]         stat_pkt_cnt,
    output logic [47:0]         stat_byte_cnt,
    output logic [15:0]         stat_hdr_err,
    output logic [15:0]         stat_seq_err,
    output logic [31:0]         stat_lat_max,
    output logic [15:0]         unmapped_cnt,
    output logic                err_pulse
);

    localparam int unsigned ACC_W = 32;

    state_e            state_q, state_d;
    logic              hdr_beat_c, body_beat_c, last_beat_c;
    logic              tready_q;
    logic              accept;
    logic [ACC_W-1:0]  beat_bytes;
    logic [PORT_W-1:0] src_port;
    logic              beat_unmapped, beat_hdr_ok;
    logic              unused_bits;

    logic [FLOW_W-1:0] cur_flow_q, cur_flow_d;
    logic              cur_unmapped_q, cur_unmapped_d;
    logic              cur_hdr_ok_q, cur_hdr_ok_d;
    logic [SEQ_W-1:0]  cur_seq_q, cur_seq_d;
    logic [TS_W-1:0]   cur_ts_q, cur_ts_d;
    logic [ACC_W-1:0]  cur_bytes_q, cur_bytes_d;

    logic              cmt_valid_q;
    logic [FLOW_W-1:0] cmt_flow_q;
    logic              cmt_unmapped_q, cmt_hdr_ok_q;
    logic [SEQ_W-1:0]  cmt_seq_q;
    logic [TS_W-1:0]   cmt_ts_q;
    logic [ACC_W-1:0]  cmt_bytes_q;

    logic [SEQ_W-1:0]  exp_q [NUM_FLOWS];
    logic [SEQ_W-1:0]  exp_seq;
    logic              cmt_seq_bad, cmt_mapped, cmt_err;
    logic [LAT_W-1:0]  cmt_lat;
    logic [ERR_W-1:0]  unmapped_q;
    logic              err_pulse_q;
    flow_stat_t        rd_stat;

    assign accept        = s_axis_tvalid & tready_q;
    assign beat_bytes    = ACC_W'($countones(s_axis_tkeep));
    assign src_port      = s_axis_tdata[SRC_PORT_OFF +: PORT_W];
    assign beat_unmapped = (src_port >> FLOW_W) != '0;
    assign beat_hdr_ok   = (s_axis_tdata[DST_MAC_OFF  +: MAC_W]   == GLOBAL_DST_MAC)
                         & (s_axis_tdata[PROTO_OFF    +: PROTO_W] == GLOBAL_PROTOCOL)
                         & (s_axis_tdata[DST_IP_OFF   +: IP_W]    == GLOBAL_DST_IP)
                         & (s_axis_tdata[DST_PORT_OFF +: PORT_W]  == GLOBAL_DST_PORT);
    // Payload and ethertype bits are carried but never inspected
    assign unused_bits   = ^s_axis_tdata;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR:  if (accept && !s_axis_tlast) state_d = ST_BODY;
            ST_BODY: if (accept && s_axis_tlast)  state_d = ST_HDR;
            default: state_d = ST_HDR;
        endcase
    end

    always_comb begin
        hdr_beat_c  = 1'b0;
        body_beat_c = 1'b0;
        case (state_q)
            ST_HDR:  hdr_beat_c  = accept;
            ST_BODY: body_beat_c = accept;
            default: hdr_beat_c  = 1'b0;
        endcase
        last_beat_c = accept & s_axis_tlast;
    end

    // In-flight packet context
    always_comb begin
        cur_flow_d     = cur_flow_q;
        cur_unmapped_d = cur_unmapped_q;
        cur_hdr_ok_d   = cur_hdr_ok_q;
        cur_seq_d      = cur_seq_q;
        cur_ts_d       = cur_ts_q;
        cur_bytes_d    = cur_bytes_q;
        if (hdr_beat_c) begin
            cur_flow_d     = src_port[FLOW_W-1:0];
            cur_unmapped_d = beat_unmapped;
            cur_hdr_ok_d   = beat_hdr_ok;
            cur_seq_d      = s_axis_tdata[SEQ_OFF +: SEQ_W];
            cur_ts_d       = s_axis_tdata[TS_OFF +: TS_W];
            cur_bytes_d    = beat_bytes;
        end else if (body_beat_c) begin
            cur_bytes_d    = cur_bytes_q + beat_bytes;
        end
    end

    // Commit-stage evaluation; a simultaneous clear makes the expected seq restart at 0
    assign exp_seq     = stat_clear ? '0 : exp_q[cmt_flow_q];
    assign cmt_seq_bad = cmt_seq_q != exp_seq;
    assign cmt_lat     = timestamp - cmt_ts_q;
    assign cmt_mapped  = cmt_valid_q & ~cmt_unmapped_q;
    assign cmt_err     = cmt_unmapped_q | ~cmt_hdr_ok_q | cmt_seq_bad;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            tready_q       <= 1'b0;
            cur_flow_q     <= '0;
            cur_unmapped_q <= 1'b0;
            cur_hdr_ok_q   <= 1'b0;
            cur_seq_q      <= '0;
            cur_ts_q       <= '0;
            cur_bytes_q    <= '0;
            cmt_valid_q    <= 1'b0;
            cmt_flow_q     <= '0;
            cmt_unmapped_q <= 1'b0;
            cmt_hdr_ok_q   <= 1'b0;
            cmt_seq_q      <= '0;
            cmt_ts_q       <= '0;
            cmt_bytes_q    <= '0;
            unmapped_q     <= '0;
            err_pulse_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
                exp_q[FLOW_W'(i)] <= '0;
            end
        end else begin
            tready_q       <= 1'b1;
            cur_flow_q     <= cur_flow_d;
            cur_unmapped_q <= cur_unmapped_d;
            cur_hdr_ok_q   <= cur_hdr_ok_d;
            cur_seq_q      <= cur_seq_d;
            cur_ts_q       <= cur_ts_d;
            cur_bytes_q    <= cur_bytes_d;
            cmt_valid_q    <= last_beat_c;
            if (last_beat_c) begin
                cmt_flow_q     <= cur_flow_d;
                cmt_unmapped_q <= cur_unmapped_d;
                cmt_hdr_ok_q   <= cur_hdr_ok_d;
                cmt_seq_q      <= cur_seq_d;
                cmt_ts_q       <= cur_ts_d;
                cmt_bytes_q    <= cur_bytes_d;
            end
            err_pulse_q <= cmt_valid_q & cmt_err;
            if (cmt_valid_q && cmt_unmapped_q) begin
                unmapped_q <= sat_inc(unmapped_q);
            end
            if (stat_clear) begin
                for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
                    exp_q[FLOW_W'(i)] <= '0;
                end
            end
            if (cmt_mapped) begin
                exp_q[cmt_flow_q] <= cmt_seq_q + SEQ_W'(1);
            end
        end
    end

    flow_stat_regs #(
        .NUM_FLOWS (NUM_FLOWS)
    ) u_regs (
        .clk_i         (axi_aclk),
        .rst_i         (axi_areset),
        .clear_i       (stat_clear),
        .commit_i      (cmt_mapped),
        .commit_flow_i (cmt_flow_q),
        .bytes_i       (BYTE_W'(cmt_bytes_q)),
        .hdr_err_i     (~cmt_hdr_ok_q),
        .seq_err_i     (cmt_seq_bad),
        .lat_i         (cmt_lat),
        .rd_sel_i      (stat_sel),
        .rd_data_o     (rd_stat)
    );

    assign s_axis_tready = tready_q;
    assign stat_pkt_cnt  = rd_stat.pkt_cnt;
    assign stat_byte_cnt = rd_stat.byte_cnt;
    assign stat_hdr_err  = rd_stat.hdr_err;
    assign stat_seq_err  = rd_stat.seq_err;
    assign stat_lat_max  = rd_stat.lat_max;
    assign unmapped_cnt  = unmapped_q;
    assign err_pulse     = err_pulse_q;

endmodule

// File: tb/tb_flow_check.sv
// Directed bench for flow_check: a vector table of single packets with hand-computed stats,
// plus hand-written sequences for back-to-back, clear ordering, reset, wrap and saturation.
module tb_flow_check;
    import flow_pkg::*;

    localparam int unsigned RX_LEN = 512;
    localparam int unsigned KEEP_W = RX_LEN / 8;
    localparam int unsigned FLOW_W = 4;

    logic              axi_aclk = 1'b0;
    logic              axi_areset = 1'b1;
    logic [31:0]       timestamp = '0;
    logic              s_axis_tvalid = 1'b0;
    logic [RX_LEN-1:0] s_axis_tdata = '0;
    logic [KEEP_W-1:0] s_axis_tkeep = '0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [FLOW_W-1:0] stat_sel = '0;
    logic              stat_clear = 1'b0;
    logic [31:0]       stat_pkt_cnt;
    logic [47:0]       stat_byte_cnt;
    logic [15:0]       stat_hdr_err;
    logic [15:0]       stat_seq_err;
    logic [31:0]       stat_lat_max;
    logic [15:0]       unmapped_cnt;
    logic              err_pulse;

    int vec_cnt = 0;
    int miscmp = 0;
    int err_cnt = 0;
    int tready_drops = 0;
    bit mon_b2b = 1'b0;

    flow_check u_dut (
        .axi_aclk      (axi_aclk),
        .axi_areset    (axi_areset),
        .timestamp     (timestamp),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .stat_sel      (stat_sel),
        .stat_clear    (stat_clear),
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_byte_cnt (stat_byte_cnt),
        .stat_hdr_err  (stat_hdr_err),
        .stat_seq_err  (stat_seq_err),
        .stat_lat_max  (stat_lat_max),
        .unmapped_cnt  (unmapped_cnt),
        .err_pulse     (err_pulse)
    );

    always #5 axi_aclk = ~axi_aclk;

    always @(negedge axi_aclk) begin
        if (err_pulse) err_cnt++;
        if (mon_b2b && !s_axis_tready) tready_drops++;
    end

    typedef struct {
        logic [15:0] src;
        logic [15:0] dport;
        logic [31:0] seq;
        logic [31:0] lat;
        int          nbeats;
        logic [63:0] lkeep;
        logic [31:0] e_pkt;
        logic [47:0] e_byte;
        logic [15:0] e_hdr;
        logic [15:0] e_seq;
        logic [31:0] e_lat;
        int          e_errp;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge axi_aclk);
        #1;
        timestamp = timestamp + 32'd1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '0;
        repeat (n) step();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RX_LEN-1:0] build_beat(input logic [15:0] src, input logic [15:0] dport,
                                                      input logic [31:0] seq, input logic [31:0] ts);
        logic [RX_LEN-1:0] b;
        b = {16{$urandom}};
        b[DST_MAC_OFF  +: 48] = 48'h001112345678;
        b[ETYPE_OFF    +: 16] = 16'h0800;
        b[PROTO_OFF    +: 8]  = 8'h06;
        b[DST_IP_OFF   +: 32] = 32'hC0A8640A;
        b[SRC_PORT_OFF +: 16] = src;
        b[DST_PORT_OFF +: 16] = dport;
        b[SEQ_OFF      +: 32] = seq;
        b[TS_OFF       +: 32] = ts;
        return b;
    endfunction

    // Present one beat and hold it until the sink takes it (bounded)
    task automatic drive_beat(input logic [RX_LEN-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        n = 0;
        while (!s_axis_tready && n < 20) begin
            step();
            n++;
        end
        if (!s_axis_tready) chk("tready_timeout", 64'(s_axis_tready), 64'd1);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] src, input logic [15:0] dport, input logic [31:0] seq,
                            input logic [31:0] ts, input int nbeats, input logic [KEEP_W-1:0] lkeep);
        for (int i = 0; i < nbeats; i++) begin
            drive_beat((i == 0) ? build_beat(src, dport, seq, ts) : {16{$urandom}},
                       (i == nbeats - 1) ? lkeep : {KEEP_W{1'b1}}, i == nbeats - 1);
        end
    endtask

    task automatic read_stat(input int f);
        stat_sel = FLOW_W'(f);
        step();
        step();
    endtask

    task automatic chk_flow(input string tag, input int f, input logic [31:0] e_pkt, input logic [47:0] e_byte,
                            input logic [15:0] e_hdr, input logic [15:0] e_seq, input logic [31:0] e_lat);
        read_stat(f);
        chk({tag, "_pkt"},  64'(stat_pkt_cnt),  64'(e_pkt));
        chk({tag, "_byte"}, 64'(stat_byte_cnt), 64'(e_byte));
        chk({tag, "_hdr"},  64'(stat_hdr_err),  64'(e_hdr));
        chk({tag, "_seq"},  64'(stat_seq_err),  64'(e_seq));
        chk({tag, "_lat"},  64'(stat_lat_max),  64'(e_lat));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        // src, dport, seq, lat, beats, last keep, pkt, bytes, hdr_err, seq_err, lat_max, err pulses
        vecs[0] = '{16'd3, 16'h1234, 32'd0, 32'd100, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 48'd64,  16'd0, 16'd0, 32'd100, 0};
        vecs[1] = '{16'd5, 16'h1234, 32'd0, 32'd10,  2, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 48'd128, 16'd0, 16'd0, 32'd10,  0};
        vecs[2] = '{16'd5, 16'h1234, 32'd1, 32'd5,   1, 64'h0000_0000_0000_000F, 32'd2, 48'd132, 16'd0, 16'd0, 32'd10,  0};
        vecs[3] = '{16'd5, 16'h1234, 32'd3, 32'd50,  1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd3, 48'd196, 16'd0, 16'd1, 32'd50,  1};
        vecs[4] = '{16'd5, 16'h1234, 32'd4, 32'd1,   1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd4, 48'd260, 16'd0, 16'd1, 32'd50,  0};
        vecs[5] = '{16'd5, 16'h1234, 32'd5, 32'd2,   1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 48'd324, 16'd0, 16'd1, 32'd50,  0};
        vecs[6] = '{16'd2, 16'h4321, 32'd0, 32'd3,   1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 48'd64,  16'd1, 16'd0, 32'd3,   1};
        vecs[7] = '{16'd2, 16'h1234, 32'd1, 32'd4,   1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd2, 48'd128, 16'd1, 16'd0, 32'd4,   0};

        repeat (3) step();
        chk("rst_tready",   64'(s_axis_tready), 64'd0);
        chk("rst_pkt",      64'(stat_pkt_cnt),  64'd0);
        chk("rst_byte",     64'(stat_byte_cnt), 64'd0);
        chk("rst_lat",      64'(stat_lat_max),  64'd0);
        chk("rst_unmapped", 64'(unmapped_cnt),  64'd0);
        chk("rst_errpulse", 64'(err_pulse),     64'd0);
        axi_areset = 1'b0;
        step();
        step();
        chk("tready_up", 64'(s_axis_tready), 64'd1);

        foreach (vecs[i]) begin
            e0 = err_cnt;
            send_pkt(vecs[i].src, vecs[i].dport, vecs[i].seq,
                     timestamp + 32'(vecs[i].nbeats) - vecs[i].lat, vecs[i].nbeats, vecs[i].lkeep);
            idle(3);
            chk_flow($sformatf("v%0d", i), int'(vecs[i].src[3:0]), vecs[i].e_pkt, vecs[i].e_byte,
                     vecs[i].e_hdr, vecs[i].e_seq, vecs[i].e_lat);
            chk($sformatf("v%0d_errp", i), 64'(err_cnt - e0), 64'(vecs[i].e_errp));
        end

        // Unmapped source port: global counter only
        e0 = err_cnt;
        send_pkt(16'h0100, 16'h1234, 32'd0, timestamp, 1, '1);
        idle(3);
        chk("unmapped_cnt", 64'(unmapped_cnt), 64'd1);
        chk("unmapped_errp", 64'(err_cnt - e0), 64'd1);
        read_stat(0);
        chk("unmapped_f0_pkt", 64'(stat_pkt_cnt), 64'd0);
        chk("unmapped_f0_byte", 64'(stat_byte_cnt), 64'd0);

        // Back-to-back 8-beat packets on all flows after a clear
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        idle(2);
        e0 = err_cnt;
        mon_b2b = 1'b1;
        for (int f = 0; f < 16; f++) begin
            send_pkt(16'(f), 16'h1234, 32'd0, timestamp + 32'd8 - 32'd20, 8, 64'h0000_0000_0000_00FF);
        end
        idle(3);
        mon_b2b = 1'b0;
        chk("b2b_tready_drops", 64'(tready_drops), 64'd0);
        chk("b2b_errp", 64'(err_cnt - e0), 64'd0);
        for (int f = 0; f < 16; f++) begin
            read_stat(f);
            chk($sformatf("b2b_f%0d_pkt", f), 64'(stat_pkt_cnt), 64'd1);
            chk($sformatf("b2b_f%0d_byte", f), 64'(stat_byte_cnt), 64'd456);
        end

        // Clear in the commit cycle of a flow-7 packet: only that packet survives, seq restarts at 0
        e0 = err_cnt;
        send_pkt(16'd1, 16'h1234, 32'd1, timestamp, 1, '1);
        send_pkt(16'd7, 16'h1234, 32'd0, timestamp + 32'd1 - 32'd9, 1, '1);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        idle(3);
        chk_flow("clr_f7", 7, 32'd1, 48'd64, 16'd0, 16'd0, 32'd9);
        chk("clr_errp", 64'(err_cnt - e0), 64'd0);
        read_stat(1);
        chk("clr_f1_pkt", 64'(stat_pkt_cnt), 64'd0);
        read_stat(0);
        chk("clr_f0_pkt", 64'(stat_pkt_cnt), 64'd0);

        // Reset in the middle of a packet, then a fresh packet must parse as beat 0
        drive_beat(build_beat(16'd9, 16'h1234, 32'd0, timestamp), '1, 1'b0);
        drive_beat({16{$urandom}}, '1, 1'b0);
        axi_areset = 1'b1;
        step();
        step();
        axi_areset = 1'b0;
        step();
        send_pkt(16'd9, 16'h1234, 32'd0, timestamp + 32'd1 - 32'd7, 1, '1);
        idle(3);
        chk_flow("rstmid_f9", 9, 32'd1, 48'd64, 16'd0, 16'd0, 32'd7);
        chk("rstmid_unmapped", 64'(unmapped_cnt), 64'd0);

        // Latency across timestamp wrap: ts FFFFFFF0, commit cycle timestamp 0x10
        timestamp = 32'h0000_000F;
        send_pkt(16'd10, 16'h1234, 32'd0, 32'hFFFF_FFF0, 1, '1);
        chk("wrap_commit_ts", 64'(timestamp), 64'h10);
        idle(3);
        chk_flow("wrap_f10", 10, 32'd1, 48'd64, 16'd0, 16'd0, 32'h20);

        // Header-error counter saturation
        for (int i = 0; i < 70000; i++) begin
            send_pkt(16'd11, 16'h4321, 32'(i), timestamp + 32'd1 - 32'd1, 1, '1);
        end
        idle(3);
        chk_flow("sat_f11", 11, 32'd70000, 48'd4480000, 16'hFFFF, 16'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
